// File: rtl/demux1x16_tdm_if.sv
// Bus bundle for the 1x16 TDM demultiplexer: serial slot input side and
// the parallel frame output side.
interface demux1x16_tdm_if;
  logic        din;
  logic        din_valid;
  logic        frame_start;
  logic [15:0] out;
  logic        out_valid;
  logic        frame_err;
  logic [3:0]  slot;

  // Upstream link / consumer side: drives the serial stream, observes frames.
  modport master (
    output din, din_valid, frame_start,
    input  out, out_valid, frame_err, slot
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, frame_start,
    output out, out_valid, frame_err, slot
  );
endinterface

// File: rtl/demux1x16_tdm.sv
// Serial TDM demultiplexer: collects 16 slot bits framed by a start marker
// and publishes the completed frame as one word with a single-cycle pulse.
//
// state   | meaning
// IDLE    | no frame in progress; waiting for a valid bit with frame_start
// COLLECT | frame in progress; slot_q is the index of the next expected bit
module demux1x16_tdm #(
  parameter int GAP_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux1x16_tdm_if.slave     bus
);

  // A zero GAP_MAX still needs a one-bit counter so the port widths stay legal.
  localparam int GAP_W = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state;
  logic [15:0]        asm_q;
  logic [15:0]        asm_next;
  logic [3:0]         slot_q;
  logic [GAP_W-1:0]   gap_q;
  logic [15:0]        out_q;
  logic               out_valid_q;
  logic               frame_err_q;

  // Assembly word with the current bit merged in, so completion loads all 16 slots.
  always_comb begin
    asm_next         = asm_q;
    asm_next[slot_q] = bus.din;
  end

  // Frame sequencing, assembly, gap timeout and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      asm_q       <= '0;
      slot_q      <= '0;
      gap_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid && bus.frame_start) begin
            asm_q[0] <= bus.din;
            slot_q   <= 4'd1;
            gap_q    <= '0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.din_valid) begin
            gap_q <= '0;
            if (bus.frame_start) begin
              // Premature restart: drop the partial frame, this bit is slot 0.
              frame_err_q <= 1'b1;
              asm_q[0]    <= bus.din;
              slot_q      <= 4'd1;
            end else if (slot_q == 4'd15) begin
              asm_q       <= asm_next;
              out_q       <= asm_next;
              out_valid_q <= 1'b1;
              slot_q      <= 4'd0;
              state       <= IDLE;
            end else begin
              asm_q  <= asm_next;
              slot_q <= slot_q + 4'd1;
            end
          end else if ((GAP_MAX != 0) && (gap_q == GAP_W'(GAP_MAX))) begin
            // GAP_MAX idle cycles already tolerated; this one more aborts the frame.
            frame_err_q <= 1'b1;
            slot_q      <= 4'd0;
            state       <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.slot      = slot_q;

endmodule

// File: doc/demux1x16_tdm.md
# demux1x16_tdm

Serial time-division demultiplexer, the receive-side counterpart of the 16:1 channel mux. Accepts a one-bit-per-slot TDM stream framed by a start marker. Routes slot k to output bit k and publishes the completed 16-bit frame as one double-buffered word with a one-cycle valid pulse. Sits between a serial link and parallel consumers of the 16 channels.

## Interface
- GAP_MAX, 8, maximum consecutive idle cycles (din_valid low) tolerated inside a frame; 0 disables the timeout
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din carries a slot bit this cycle
- frame_start  input  1  qualified by din_valid; marks the bit as slot 0
- out  output  16  last completed frame; out[k] = slot k
- out_valid  output  1  one-cycle pulse when out is updated
- frame_err  output  1  one-cycle pulse on an aborted frame
- slot  output  4  index of the next slot expected (debug)

## Operation
- State machine with two states, IDLE and COLLECT. A 16-bit assembly register, a 4-bit slot counter, and a gap counter of width clog2(GAP_MAX+1).
- IDLE:
  - din_valid && frame_start: write din to assembly bit 0, set slot=1, clear the gap counter, go to COLLECT.
  - din_valid without frame_start: bit discarded, no error.
  - frame_start without din_valid: ignored.
- COLLECT, din_valid && !frame_start: write din to assembly bit [slot] and clear the gap counter.
  - If slot==15: load out with the full assembled word including this bit, pulse out_valid, set slot=0, go to IDLE.
  - Otherwise increment slot.
- COLLECT, din_valid && frame_start (premature restart):
  - Pulse frame_err and discard the partial frame. out is unchanged.
  - Treat din as slot 0 of a new frame: slot=1, stay in COLLECT.
- COLLECT, !din_valid: the gap counter increments. When GAP_MAX≠0 and the counter reaches GAP_MAX:
  - Pulse frame_err, set slot=0, go to IDLE.
  - The partial frame is discarded and out is unchanged.
- out is double-buffered. It changes only on a frame completion and holds its value between completions.
- Assembly bits not yet written in the current frame are don't-care. They are never exposed, because out loads only when all 16 slots are written.
- Precedence within one cycle: reset > valid data bit (completion or restart) > gap timeout. A valid bit arriving in the cycle the gap counter would expire is accepted, and no error is raised.

## Timing
- Reset (async assert, sync release by the surrounding reset tree) forces:
  - state=IDLE, slot=0, gap counter=0
  - out=16'h0000, out_valid=0, frame_err=0
- Reset mid-frame discards the partial frame with no error pulse.
- Latency: out and out_valid change on the clock edge that accepts slot 15. They are visible in the cycle after the 16th bit is presented.
- Minimum frame is 16 consecutive cycles, so back-to-back frames give an out_valid pulse every 16 cycles.
- A new frame_start in the cycle immediately after completion is accepted with no dead cycle.
- frame_err is registered. It is high for exactly the one cycle after the offending edge.
- out_valid and frame_err are never high together.
- The slot counter wraps 15→0 only via the completion path. The +1 increment never wraps on its own.

## Test plan
- Reset: assert rst_n=0 mid-frame after 7 slots, then release and idle 20 cycles -> out=0x0000, out_valid and frame_err never pulse, slot=0.
- Contiguous frame: frame_start on slot 0, 16 consecutive bits encoding 0xA5C3 (slot k = bit k) -> one out_valid pulse, out=0xA5C3, slot returns to 0. Immediately follow with 0x0001 -> second pulse exactly 16 cycles later, out=0x0001.
- Gapped frame, GAP_MAX=8: send 0x1234 with 8-cycle idle gaps between slots -> out=0x1234, no frame_err. Repeat with one 9-cycle gap after slot 5 -> frame_err pulses once, out stays 0x1234, state returns to IDLE.
- Premature restart: 10 slots, then frame_start with a new 16-bit frame 0xFFFF -> one frame_err pulse on the restart bit, followed by out_valid with out=0xFFFF.
- Stray data: din_valid bits without frame_start while in IDLE, plus frame_start with din_valid=0 -> no out_valid, no frame_err, out unchanged.
- GAP_MAX=0: a 100-cycle gap after slot 3, then the remaining 12 slots of 0x8001 -> out=0x8001, no frame_err.
